hnoc_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one HNoC switch output link among NumIn input links.
//  A flit competes only if its destination address lies in [DestMin,DestMax].
//  The winning flit is captured in a one-entry output register with valid/ready handshake.

---
 rtl/hnoc_pkg.sv | 33 +++
 rtl/hnoc_rr_arbiter.sv | 50 +++++
 rtl/hnoc_port_arbiter.sv | 102 ++++++++++
 tb/tb_hnoc_port_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hnoc_pkg.sv
`default_nettype none
//============================================================================
// Module   : hnoc_pkg
// Purpose  : Shared HNoC definitions: default flit/address widths, the
//            destination-field extractor and the address range test used by
//            HLeaf switch output ports.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
package hnoc_pkg;

    localparam int c_HNOC_DATA_WIDTH = 35;
    localparam int c_HNOC_ADDR_WIDTH = 3;

    // Destination address occupies the top bits of the flit.
    function automatic logic [c_HNOC_ADDR_WIDTH-1:0] flit_addr(
        input logic [c_HNOC_DATA_WIDTH-1:0] flit
    );
        return flit[c_HNOC_DATA_WIDTH-1 -: c_HNOC_ADDR_WIDTH];
    endfunction

    // Inclusive range test; integer arguments let callers with any address
    // width share it.
    function automatic logic in_range(
        input int unsigned addr,
        input int unsigned lo,
        input int unsigned hi
    );
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hnoc_rr_arbiter.sv
`default_nettype none
//============================================================================
// Module   : hnoc_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Picks the lowest requesting
//            index at or above i_ptr, wrapping modulo NUM_IN.
// Ports    : i_req       - request vector
//            i_ptr       - round-robin start index
//            o_grant     - one-hot grant (zero when nothing requests)
//            o_grant_idx - binary index of the granted request
//            o_any_grant - at least one request present
// Revision : 1.0 - initial release
//============================================================================
module hnoc_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  wire logic [NUM_IN-1:0] i_req,
    input  wire logic [IDX_W-1:0]  i_ptr,
    output logic      [NUM_IN-1:0] o_grant,
    output logic      [IDX_W-1:0]  o_grant_idx,
    output logic                   o_any_grant
);

    logic [2*NUM_IN-1:0] w_req_dbl;
    logic [2*NUM_IN-1:0] w_mask;
    logic [2*NUM_IN-1:0] w_masked;

    // Lower copy is masked below the pointer; the unmasked upper copy
    // supplies the wrapped-around candidates, so one lowest-bit search covers
    // the whole circular order.
    assign w_req_dbl = {i_req, i_req};
    assign w_mask    = ~(({{(2*NUM_IN-1){1'b0}}, 1'b1} << i_ptr) - 1'b1);
    assign w_masked  = w_req_dbl & w_mask;

    // Descending scan: the last hit written is the lowest set bit.
    always_comb begin
        o_any_grant = 1'b0;
        o_grant_idx = '0;
        for (int i = 2*NUM_IN-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                o_any_grant = 1'b1;
                o_grant_idx = (i >= NUM_IN) ? IDX_W'(i - NUM_IN) : IDX_W'(i);
            end
        end
    end

    assign o_grant = o_any_grant ? (NUM_IN'(1) << o_grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/hnoc_port_arbiter.sv
`default_nettype none
//============================================================================
// Module   : hnoc_port_arbiter
// Purpose  : Shares one HNoC switch output link among NUM_IN input links.
//            Only flits whose destination lies in [DEST_MIN,DEST_MAX]
//            compete; the round-robin winner is captured in a one-entry
//            output register with a valid/ready handshake.
// Ports    : i_sclk        - clock
//            i_reset       - synchronous reset, active low
//            i_req_data    - input flits, input k at [k*DATA_WIDTH +: DATA_WIDTH]
//            i_req_valid   - per-input flit valid
//            o_req_ready   - per-input accept (one-hot or zero)
//            o_data        - registered output flit
//            o_data_valid  - output flit valid
//            i_data_ready  - downstream accept
//            o_grant_id    - input index that supplied o_data
// Revision : 1.0 - initial release
//============================================================================
module hnoc_port_arbiter
    import hnoc_pkg::*;
#(
    parameter int          DATA_WIDTH = c_HNOC_DATA_WIDTH,
    parameter int          ADDR_WIDTH = c_HNOC_ADDR_WIDTH,
    parameter int          NUM_IN     = 4,
    parameter int unsigned DEST_MIN   = 0,
    parameter int unsigned DEST_MAX   = 7
) (
    input  wire logic                         i_sclk,
    input  wire logic                         i_reset,
    input  wire logic [NUM_IN*DATA_WIDTH-1:0] i_req_data,
    input  wire logic [NUM_IN-1:0]            i_req_valid,
    output logic      [NUM_IN-1:0]            o_req_ready,
    output logic      [DATA_WIDTH-1:0]        o_data,
    output logic                              o_data_valid,
    input  wire logic                         i_data_ready,
    output logic      [$clog2(NUM_IN)-1:0]    o_grant_id
);

    localparam int c_IDX_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0]     w_eligible;
    logic [NUM_IN-1:0]     w_grant;
    logic [c_IDX_W-1:0]    w_grant_idx;
    logic                  w_any_grant;
    logic                  w_can_load;
    logic                  w_xfer;
    logic [c_IDX_W-1:0]    w_ptr_next;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_valid;
    logic [c_IDX_W-1:0]    r_grant_id;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_elig
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr        = i_req_data[k*DATA_WIDTH + DATA_WIDTH-1 -: ADDR_WIDTH];
        assign w_eligible[k] = i_req_valid[k] && in_range(32'(w_addr), DEST_MIN, DEST_MAX);
    end

    hnoc_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (c_IDX_W)
    ) u_rr_arbiter (
        .i_req       (w_eligible),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // The output slot frees up in the same cycle the downstream accepts,
    // which is what gives back-to-back flits without a bubble.
    assign w_can_load  = !r_data_valid || i_data_ready;
    assign o_req_ready = (i_reset && w_can_load) ? w_grant : '0;
    assign w_xfer      = w_any_grant && (|o_req_ready);

    assign w_sel_data  = i_req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next  = (w_grant_idx == c_IDX_W'(NUM_IN-1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge i_sclk) begin
        if (!i_reset) begin
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
        end else if (w_xfer) begin
            r_data_valid <= 1'b1;
            r_data       <= w_sel_data;
            r_grant_id   <= w_grant_idx;
            r_rr_ptr     <= w_ptr_next;
        end else if (i_data_ready) begin
            r_data_valid <= 1'b0;
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_grant_id   = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_hnoc_port_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_hnoc_port_arbiter
// Purpose  : Self-checking bench for hnoc_port_arbiter (range 4..7, 4 inputs).
//            A reference model predicts ready bits and pushes expected output
//            flits into a scoreboard queue; a monitor pops on each downstream
//            accept and compares.
// Revision : 1.0 - initial release
//============================================================================
module tb_hnoc_port_arbiter;

    localparam int DW   = 35;
    localparam int AW   = 3;
    localparam int N    = 4;
    localparam int DMIN = 4;
    localparam int DMAX = 7;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
    } exp_t;

    logic            clk = 1'b0;
    logic            r_rst;
    logic [N*DW-1:0] r_req_data;
    logic [N-1:0]    r_req_valid;
    logic            r_rdy;
    logic [DW-1:0]   r_flit [N];

    logic [N-1:0]    w_req_ready;
    logic [DW-1:0]   w_data;
    logic            w_data_valid;
    logic [1:0]      w_grant_id;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    bit   m_valid = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hnoc_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_IN     (N),
        .DEST_MIN   (DMIN),
        .DEST_MAX   (DMAX)
    ) dut (
        .i_sclk       (clk),
        .i_reset      (r_rst),
        .i_req_data   (r_req_data),
        .i_req_valid  (r_req_valid),
        .o_req_ready  (w_req_ready),
        .o_data       (w_data),
        .o_data_valid (w_data_valid),
        .i_data_ready (r_rdy),
        .o_grant_id   (w_grant_id)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_flit(input int addr);
        logic [DW-AW-1:0] payload;
        logic [AW-1:0]    a;
        payload = (DW-AW)'($urandom);
        a       = AW'(addr);
        return {a, payload};
    endfunction

    // One clock cycle: drive after the edge, predict and check before the next.
    task automatic step(input bit rst_n, input logic [N-1:0] vld, input bit rdy);
        logic [N-1:0] exp_rdy;
        int           g;
        int           addr;
        int           k;
        #1;
        r_rst       = rst_n;
        r_req_valid = vld;
        r_rdy       = rdy;
        for (int i = 0; i < N; i++) r_req_data[i*DW +: DW] = r_flit[i];
        #3;
        check("data_valid", 64'(w_data_valid), 64'(m_valid));
        g = -1;
        if (rst_n && (!m_valid || rdy)) begin
            for (int j = 0; j < N; j++) begin
                k    = (m_ptr + j) % N;
                addr = int'(r_flit[k][DW-1 -: AW]);
                if (g < 0 && vld[k] && addr >= DMIN && addr <= DMAX) g = k;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(w_req_ready), 64'(exp_rdy));
        if (!rst_n) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            sb_q.push_back('{r_flit[g], g});
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
    endtask

    // Monitor: every downstream accept must match the oldest expected flit.
    always @(negedge clk) begin
        exp_t e;
        if (r_rst === 1'b1 && w_data_valid === 1'b1 && r_rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(w_data_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(w_data), 64'(e.data));
                check("out_grant_id", 64'(w_grant_id), 64'(e.id));
            end
        end
    end

    initial begin
        r_rst       = 1'b0;
        r_req_valid = '0;
        r_rdy       = 1'b0;
        r_req_data  = '0;
        for (int i = 0; i < N; i++) r_flit[i] = mk_flit(5);
        @(posedge clk);

        // Reset held with every input valid and in range.
        repeat (3) step(1'b0, 4'hF, 1'b1);
        @(negedge clk);
        check("reset_data", 64'(w_data), 64'd0);
        check("reset_grant_id", 64'(w_grant_id), 64'd0);
        @(posedge clk);
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'h0, 1'b1);

        // Single input 2 at address 5.
        r_flit[2] = mk_flit(5);
        step(1'b1, 4'b0100, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        // All inputs streaming for 8 cycles.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) r_flit[i] = mk_flit(int'($urandom_range(DMIN, DMAX)));
            step(1'b1, 4'hF, 1'b1);
        end

        // Backpressure: output full and stalled for 5 cycles, then release.
        repeat (5) step(1'b1, 4'hF, 1'b0);
        repeat (4) step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'h0, 1'b1);

        // Filtering: input 1 out of range, input 3 in range.
        r_flit[1] = mk_flit(2);
        r_flit[3] = mk_flit(6);
        repeat (6) step(1'b1, 4'b1010, 1'b1);
        step(1'b1, 4'b0010, 1'b1);

        // Reset while full and while input 3 is requesting.
        r_flit[3] = mk_flit(7);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b1);
        repeat (2) step(1'b1, 4'b0000, 1'b1);
        repeat (2) step(1'b1, 4'b1000, 1'b1);

        // Randomized traffic, backpressure and occasional reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) r_flit[i] = mk_flit(int'($urandom_range(0, 7)));
            step(($urandom_range(0, 99) != 0), N'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Drain and confirm nothing was left behind.
        repeat (3) step(1'b1, 4'h0, 1'b1);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
